// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, the imem request handshake and the IF/ID register with a one-entry skid.
// One instruction per cycle; the first instruction reaches IF/ID on the 2nd edge after reset; a redirect costs one bubble.
// Backpressure: stall freezes PC and IF/ID, and an instruction accepted under stall parks in the skid until release.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic [5:0]  opcode,
    output logic [5:0]  func
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
    } ifid_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] skid, skid_nxt;
    ifid_t       ifid, ifid_nxt;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        accept;

    assign pc_plus4 = pc + 32'd4;
    assign target   = {redirect_pc[31:2], 2'b00};
    assign imem_req = (state == FETCH);
    assign imem_addr = pc;
    assign accept   = imem_req & imem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
            skid  <= 32'd0;
            ifid  <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            skid  <= skid_nxt;
            ifid  <= ifid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        skid_nxt  = skid;
        ifid_nxt  = ifid;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                // Redirect outranks stall: the wrong-path word is dropped even if accepted.
                if (redirect) begin
                    pc_nxt         = target;
                    ifid_nxt.valid = 1'b0;
                end else if (accept && !stall) begin
                    ifid_nxt.valid = 1'b1;
                    ifid_nxt.instr = imem_rdata;
                    ifid_nxt.pc4   = pc_plus4;
                    pc_nxt         = pc_plus4;
                end else if (accept && stall) begin
                    skid_nxt  = imem_rdata;
                    state_nxt = HOLD;
                end else if (!stall) begin
                    ifid_nxt.valid = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nxt         = target;
                    ifid_nxt.valid = 1'b0;
                    skid_nxt       = 32'd0;
                    state_nxt      = FETCH;
                end else if (!stall) begin
                    ifid_nxt.valid = 1'b1;
                    ifid_nxt.instr = skid;
                    ifid_nxt.pc4   = pc_plus4;
                    pc_nxt         = pc_plus4;
                    state_nxt      = FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign ifid_valid = ifid.valid;
    assign ifid_instr = ifid.instr;
    assign ifid_pc4   = ifid.pc4;
    // A bubble decodes as a harmless R-type nop.
    assign opcode = ifid.valid ? ifid.instr[31:26] : 6'd0;
    assign func   = ifid.valid ? ifid.instr[5:0]   : 6'd0;

endmodule
